// File: rtl/dmem_host_ctrl_if.sv
// ----------------------------------------------------------------------------
// dmem_host_ctrl_if
// Bundles the host controller's handshake and data-memory port signals.
//   master : the controller (drives memory ports, START, stream outputs)
//   slave  : the environment (operand source, core, data memory, result sink)
// Signals:
//   go / busy / done / timeout_err        sequence control and status
//   in_valid / in_data / in_ready         operand stream into the controller
//   START / END                           core handshake
//   addr_mux_select                       00 core, 01 host write, 10 host read
//   current_addr / write_from_tb / mem_data  host write port
//   ar_in / dmem_rdata                    host read port
//   out_valid / out_data / out_ready      result stream out of the controller
// ----------------------------------------------------------------------------
interface dmem_host_ctrl_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              go;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              START;
    logic              END;
    logic [1:0]        addr_mux_select;
    logic [ADDR_W-1:0] current_addr;
    logic              write_from_tb;
    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] ar_in;
    logic [DATA_W-1:0] dmem_rdata;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        input  go, in_valid, in_data, END, dmem_rdata, out_ready,
        output in_ready, START, addr_mux_select, current_addr, write_from_tb, mem_data,
        output ar_in, out_valid, out_data, busy, done, timeout_err
    );

    modport slave (
        output go, in_valid, in_data, END, dmem_rdata, out_ready,
        input  in_ready, START, addr_mux_select, current_addr, write_from_tb, mem_data,
        input  ar_in, out_valid, out_data, busy, done, timeout_err
    );
endinterface

// File: rtl/dmem_host_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_host_ctrl
// Host-side sequencer for the matrix-multiply top: loads LOAD_LEN operand words
// into data memory, pulses START, waits (bounded by TIMEOUT) for END, then reads
// RESULT_LEN words back out as a valid/ready stream and pulses done.
// Ports:
//   clk     : system clock, rising edge
//   RESET   : synchronous active-high reset
//   io_bus  : dmem_host_ctrl_if master modport (handshakes and memory ports)
// ----------------------------------------------------------------------------
module dmem_host_ctrl #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned LOAD_BASE   = 0,
    parameter int unsigned LOAD_LEN    = 16,
    parameter int unsigned RESULT_BASE = 64,
    parameter int unsigned RESULT_LEN  = 16,
    parameter int unsigned READ_LAT    = 1,
    parameter int unsigned TIMEOUT     = 65535
) (
    input logic               clk,
    input logic               RESET,
    dmem_host_ctrl_if.master  io_bus
);

    typedef enum logic [2:0] {
        StIdle, StLoad, StKick, StWaitEnd, StRdAddr, StRdWait, StRdOut, StFin
    } state_e;

    localparam logic [ADDR_W-1:0] LoadBase   = ADDR_W'(LOAD_BASE);
    localparam logic [ADDR_W-1:0] ResultBase = ADDR_W'(RESULT_BASE);

    state_e            r_state, w_state_nxt;
    logic [31:0]       r_cnt, w_cnt_nxt;      // word counter, shared by load and dump
    logic [31:0]       r_tmo, w_tmo_nxt;      // END wait counter
    logic [2:0]        r_lat, w_lat_nxt;      // read-latency wait counter
    logic [DATA_W-1:0] r_out_data, w_out_data_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;

    // Addresses wrap modulo 2^ADDR_W by truncation.
    logic [ADDR_W-1:0] w_load_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    assign w_load_addr = LoadBase + r_cnt[ADDR_W-1:0];
    assign w_rd_addr   = ResultBase + r_cnt[ADDR_W-1:0];

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_tmo         <= '0;
            r_lat         <= '0;
            r_out_data    <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_tmo         <= w_tmo_nxt;
            r_lat         <= w_lat_nxt;
            r_out_data    <= w_out_data_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign io_bus.out_data    = r_out_data;
    assign io_bus.timeout_err = r_timeout_err;
    assign io_bus.busy        = (r_state != StIdle);

    always_comb begin
        w_state_nxt               = r_state;
        w_cnt_nxt                 = r_cnt;
        w_tmo_nxt                 = r_tmo;
        w_lat_nxt                 = r_lat;
        w_out_data_nxt            = r_out_data;
        w_timeout_err_nxt         = r_timeout_err;
        io_bus.in_ready           = 1'b0;
        io_bus.START              = 1'b0;
        io_bus.addr_mux_select    = 2'b00;
        io_bus.current_addr       = '0;
        io_bus.write_from_tb      = 1'b0;
        io_bus.mem_data           = '0;
        io_bus.ar_in              = '0;
        io_bus.out_valid          = 1'b0;
        io_bus.done               = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (io_bus.go) begin
                    w_cnt_nxt         = '0;
                    w_timeout_err_nxt = 1'b0;
                    w_state_nxt       = (LOAD_LEN == 0) ? StKick : StLoad;
                end
            end
            StLoad: begin
                io_bus.addr_mux_select = 2'b01;
                io_bus.in_ready        = 1'b1;
                io_bus.current_addr    = w_load_addr;
                if (io_bus.in_valid) begin
                    io_bus.write_from_tb = 1'b1;
                    io_bus.mem_data      = io_bus.in_data;
                    w_cnt_nxt            = r_cnt + 32'd1;
                    if (r_cnt == LOAD_LEN - 1) begin
                        w_state_nxt = StKick;
                    end
                end
            end
            StKick: begin
                io_bus.START = 1'b1;
                w_tmo_nxt    = '0;
                w_state_nxt  = StWaitEnd;
            end
            StWaitEnd: begin
                // END wins over a timeout expiring in the same cycle.
                if (io_bus.END) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (RESULT_LEN == 0) ? StFin : StRdAddr;
                end else if (r_tmo == TIMEOUT - 1) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = StFin;
                end else begin
                    w_tmo_nxt = r_tmo + 32'd1;
                end
            end
            StRdAddr: begin
                io_bus.addr_mux_select = 2'b10;
                io_bus.ar_in           = w_rd_addr;
                w_lat_nxt              = '0;
                if (READ_LAT == 0) begin
                    w_out_data_nxt = io_bus.dmem_rdata;
                    w_state_nxt    = StRdOut;
                end else begin
                    w_state_nxt = StRdWait;
                end
            end
            StRdWait: begin
                io_bus.addr_mux_select = 2'b10;
                io_bus.ar_in           = w_rd_addr;
                if (r_lat == 3'(READ_LAT - 1)) begin
                    w_out_data_nxt = io_bus.dmem_rdata;
                    w_state_nxt    = StRdOut;
                end else begin
                    w_lat_nxt = r_lat + 3'd1;
                end
            end
            StRdOut: begin
                io_bus.addr_mux_select = 2'b10;
                io_bus.ar_in           = w_rd_addr;
                io_bus.out_valid       = 1'b1;
                if (io_bus.out_ready) begin
                    w_cnt_nxt   = r_cnt + 32'd1;
                    w_state_nxt = (r_cnt == RESULT_LEN - 1) ? StFin : StRdAddr;
                end
            end
            StFin: begin
                io_bus.done = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

endmodule

// File: doc/dmem_host_ctrl.md
# dmem_host_ctrl

Host-side controller for the matrix-multiply top level: it drives the data-memory write/read ports and core handshake that the top exposes to the testbench. It streams a block of operand words into data memory, pulses START, waits for END, then reads a result window back out of data memory as a valid/ready stream. It turns the manual testbench sequence into one reusable sequential block.

## Interface
- ADDR_W, 16: data-memory address width.
- DATA_W, 16: data word width.
- LOAD_BASE, 0: first data-memory address written during load.
- LOAD_LEN, 16: number of operand words loaded; 0 permitted.
- RESULT_BASE, 64: first data-memory address read during dump.
- RESULT_LEN, 16: number of result words dumped; 0 permitted.
- READ_LAT, 1: cycles from ar_in change to valid dmem_rdata; legal range 0..7.
- TIMEOUT, 65535: maximum cycles waited for END before aborting.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- go  in  1  start request, sampled only in IDLE.
- in_valid  in  1  operand word valid.
- in_data  in  DATA_W  operand word.
- in_ready  out  1  controller accepts operand word.
- START  out  1  one-cycle start pulse to core.
- END  in  1  core completion flag, level.
- addr_mux_select  out  2  00 core owns memory, 01 host write (current_addr), 10 host read (ar_in).
- current_addr  out  ADDR_W  host write address.
- write_from_tb  out  1  host write enable.
- mem_data  out  DATA_W  host write data.
- ar_in  out  ADDR_W  host read address.
- dmem_rdata  in  DATA_W  data-memory read data.
- out_valid  out  1  result word valid.
- out_data  out  DATA_W  result word.
- out_ready  in  1  downstream accepts result word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of sequence.
- timeout_err  out  1  set on END timeout, cleared on next accepted go.

## Operation
- States: IDLE, LOAD, KICK, WAIT_END, RD_ADDR, RD_WAIT, RD_OUT, FIN.
- IDLE: mux 00, all strobes low. go=1 -> LOAD (or KICK if LOAD_LEN=0); word counter cleared, timeout_err cleared.
- LOAD: mux 01, in_ready=1. Each cycle with in_valid=1: write_from_tb=1, current_addr=LOAD_BASE+cnt, mem_data=in_data combinationally from inputs/counter; cnt increments. Last word (cnt=LOAD_LEN-1) accepted -> KICK. in_valid=0 -> write_from_tb=0, no progress.
- KICK: mux 00, START=1 for exactly this cycle -> WAIT_END; timeout counter cleared.
- WAIT_END: mux 00. END=1 -> RD_ADDR (or FIN if RESULT_LEN=0). END sampled only from the cycle after KICK. Counter reaches TIMEOUT without END -> timeout_err=1, FIN, no dump.
- RD_ADDR: mux 10, ar_in=RESULT_BASE+cnt (cnt cleared on WAIT_END exit); -> RD_WAIT, or RD_OUT directly if READ_LAT=0.
- RD_WAIT: hold ar_in, mux 10 for READ_LAT cycles, then register dmem_rdata into out_data -> RD_OUT.
- RD_OUT: out_valid=1, out_data stable, ar_in held. out_ready=1: cnt increments; last word -> FIN, else RD_ADDR.
- FIN: done=1, mux 00 -> IDLE.
- Addresses computed modulo 2^ADDR_W (wrap, no error).
- in_valid outside LOAD ignored (in_ready=0). go outside IDLE ignored. END outside WAIT_END ignored.

## Timing
- Reset values: state IDLE, addr_mux_select=00, current_addr=0, ar_in=0, mem_data=0, write_from_tb=0, START=0, in_ready=0, out_valid=0, out_data=0, busy=0, done=0, timeout_err=0, counters 0.
- RESET=1 in any state, including mid-load or mid-dump, takes effect at the next edge; outputs at reset values the following cycle; partial results are discarded.
- go=1 in IDLE -> busy=1 next cycle.
- Load throughput: one word per cycle with continuous in_valid.
- START asserted exactly one cycle after the last load handshake.
- Dump: minimum READ_LAT+2 cycles per word (RD_ADDR, READ_LAT waits, RD_OUT); out_valid held until handshake; out_data does not change while out_valid=1.
- done asserted one cycle after final out handshake, END detection when RESULT_LEN=0, or timeout.

## Test plan
- LOAD_LEN=4, BASE 0, continuous in_valid with 0x11,0x22,0x33,0x44 -> writes at addrs 0..3, mux 01 for 4 cycles, START pulse in the next cycle.
- in_valid gapped (1,0,1,1,0,1) -> write_from_tb mirrors handshakes only; addresses contiguous 0..3.
- END raised 10 cycles after START, RESULT_LEN=3, READ_LAT=1, memory 0x0A,0x0B,0x0C at 64..66 -> out_data 0x0A,0x0B,0x0C in order, done pulse after the third handshake.
- out_ready held low 5 cycles on word 2 -> out_valid and out_data stable, ar_in=65 held, no skip or duplicate.
- TIMEOUT=20, END never asserted -> timeout_err=1 and done pulse 21 cycles after START, no dump activity; next go clears timeout_err.
- RESET asserted mid-dump -> next cycle all outputs at reset values, state IDLE; a fresh go reruns the full sequence correctly.
